// File: rtl/fifo_rd_stream.sv
// Read-side drain engine: issues FIFO reads and hides the FIFO read latency behind a prefetch buffer.
// Optional burst gating is compiled in with `define FIFO_RD_STREAM_BURST_EN.
module fifo_rd_stream #(
  parameter int DATA_WIDTH  = 32,
  parameter int LEVEL_WIDTH = 11,
  parameter int RD_LATENCY  = 1,
  parameter int BURST_LEN   = 16
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst_n,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_rd_empty,
  input  logic [LEVEL_WIDTH-1:0] fifo_rd_level,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_last
);

  localparam int DEPTH = RD_LATENCY + 1;
  localparam logic [2:0] DEPTH_W = 3'(DEPTH);

  logic [DATA_WIDTH-1:0] pbuf [DEPTH];
  logic [1:0]            occ, occ_next, inflight, wr_idx;
  logic [RD_LATENCY-1:0] track;
  logic [2:0]            credit_use;
  logic                  push, pop, gate;

  assign pop        = m_valid & m_ready;
  assign push       = track[RD_LATENCY-1];
  assign occ_next   = occ + 2'(push) - 2'(pop);
  assign wr_idx     = occ - 2'(pop);
  assign m_data     = pbuf[0];

  // Credits count both buffered words and words still inside the FIFO read pipeline.
  assign credit_use = {1'b0, occ} + {1'b0, inflight} - {2'b00, pop};
  assign fifo_rd_en = rd_rst_n & ~fifo_rd_empty & gate & (credit_use < DEPTH_W);

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      occ      <= '0;
      inflight <= '0;
      track    <= '0;
      m_valid  <= 1'b0;
    end else begin
      occ      <= occ_next;
      inflight <= inflight + 2'(fifo_rd_en) - 2'(push);
      track    <= RD_LATENCY'({track, fifo_rd_en});
      m_valid  <= (occ_next != 2'd0);
    end
  end

  // Shift-register buffer: entry 0 is always the head; a push lands just past the surviving entries.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      for (int i = 0; i < DEPTH; i++) pbuf[i] <= '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) pbuf[i] <= pbuf[i+1];
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wr_idx == 2'(i))) pbuf[i] <= fifo_rd_data;
      end
    end
  end

  a_no_overflow: assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
    !(push && !pop && (occ == DEPTH_W[1:0])));

`ifdef FIFO_RD_STREAM_BURST_EN
  localparam int CW = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, SETTLE = 2'd2} state_t;

  state_t        state, state_next;
  logic [CW-1:0] issue_cnt, beat_cnt;

  assign gate   = (state == ISSUE);
  assign m_last = m_valid & (beat_cnt == CW'(BURST_LEN - 1));

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fifo_rd_level >= LEVEL_WIDTH'(BURST_LEN)) state_next = ISSUE;
      ISSUE:   if (fifo_rd_en && (issue_cnt == CW'(1)))     state_next = SETTLE;
      SETTLE:  if (inflight == 2'd0)                         state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      issue_cnt <= '0;
      beat_cnt  <= '0;
    end else begin
      if (state == IDLE && state_next == ISSUE) issue_cnt <= CW'(BURST_LEN);
      else if (state == ISSUE && fifo_rd_en)    issue_cnt <= issue_cnt - CW'(1);
      if (pop) beat_cnt <= (beat_cnt == CW'(BURST_LEN - 1)) ? '0 : beat_cnt + CW'(1);
    end
  end
`else
  logic unused_level;

  assign gate         = 1'b1;
  assign m_last       = 1'b0;
  assign unused_level = ^fifo_rd_level;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: two instances (read latency 1 and 2) fed from behavioural FIFO models.
module tb_fifo_rd_stream;
  localparam int DW = 32;
  localparam int LW = 11;
  localparam int BL = 16;
`ifdef FIFO_RD_STREAM_BURST_EN
  localparam bit BURST_MODE = 1'b1;
`else
  localparam bit BURST_MODE = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic m_ready = 1'b1;
  bit   phase_stream = 1'b0;
  bit   phase_toggle = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic          rd_en [2];
  logic          empty [2];
  logic          m_valid [2];
  logic          m_last [2];
  logic [DW-1:0] rd_data [2];
  logic [DW-1:0] m_data [2];
  logic [LW-1:0] level [2];

  task automatic chk(input int id, input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s inst=%0d actual=%0h required=%0h", name, id, act, req);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int DEPTH = g + 2;
    logic [DW-1:0] mem [0:1023];
    logic [DW-1:0] exp_q [0:1023];
    int wp = 0, rp = 0, ewr = 0, erd = 0;
    logic [DW-1:0] stage1 = '0, stage2 = '0;
    int issued, popped, beats, first_rd, reads_total, lasts;
    bit lat_done, prev_stall, exp_last;
    logic [DW-1:0] prev_data;

    // FIFO read port: data appears RD_LATENCY cycles after the read enable.
    assign empty[g]   = (rp == wp);
    assign level[g]   = LW'(wp - rp);
    assign rd_data[g] = (g == 0) ? stage1 : stage2;

    always @(posedge clk) begin
      if (rd_en[g] && rp < wp) begin
        stage1 <= mem[rp];
        rp     <= rp + 1;
      end
      stage2 <= stage1;
    end

    fifo_rd_stream #(
      .DATA_WIDTH(DW), .LEVEL_WIDTH(LW), .RD_LATENCY(g + 1), .BURST_LEN(BL)
    ) dut (
      .rd_clk(clk), .rd_rst_n(rst_n),
      .fifo_rd_en(rd_en[g]), .fifo_rd_data(rd_data[g]),
      .fifo_rd_empty(empty[g]), .fifo_rd_level(level[g]),
      .m_valid(m_valid[g]), .m_ready(m_ready),
      .m_data(m_data[g]), .m_last(m_last[g])
    );

    initial begin
      issued = 0; popped = 0; beats = 0; first_rd = -1; reads_total = 0; lasts = 0;
      lat_done = 0; prev_stall = 0; prev_data = '0;
      forever begin
        @(negedge clk); #1;
        if (!rst_n) begin
          if (cyc > 0)
            chk(g, !rd_en[g] && !m_valid[g] && m_data[g] == '0 && !m_last[g], "reset_outputs",
                longint'({rd_en[g], m_valid[g], m_last[g], |m_data[g]}), 0);
          issued = 0; popped = 0; beats = 0; first_rd = -1; reads_total = 0; lasts = 0;
          lat_done = 0; prev_stall = 0;
        end else begin
          chk(g, issued - popped <= DEPTH, "occupancy_bound", issued - popped, DEPTH);
          if (rd_en[g]) chk(g, !empty[g], "read_while_empty", empty[g], 0);
          if (phase_toggle) chk(g, rd_en[g] == !empty[g], "rd_en_align", rd_en[g], !empty[g]);
          if (phase_stream && beats > 0 && beats < 64) chk(g, m_valid[g], "stream_gap", m_valid[g], 1);
          if (prev_stall) chk(g, m_valid[g] && m_data[g] == prev_data, "stall_hold", m_data[g], prev_data);
          if (m_valid[g] && !lat_done) begin
            lat_done = 1;
            chk(g, cyc - first_rd == DEPTH, "first_word_latency", cyc - first_rd, DEPTH);
          end
          if (m_valid[g] && m_ready) begin
            chk(g, erd < ewr, "extra_beat", m_data[g], 0);
            if (erd < ewr) begin
              chk(g, m_data[g] == exp_q[erd], "data", m_data[g], exp_q[erd]);
              erd++;
            end
            exp_last = BURST_MODE && (beats % BL == BL - 1);
            chk(g, m_last[g] == exp_last, "last", m_last[g], exp_last);
            if (m_last[g]) lasts++;
            beats++;
            popped++;
          end
          if (rd_en[g]) begin
            if (first_rd < 0) first_rd = cyc;
            issued++;
            reads_total++;
          end
          prev_stall = m_valid[g] && !m_ready;
          prev_data  = m_data[g];
        end
      end
    end
  end

  task automatic push_word(input logic [DW-1:0] v);
    inst[0].mem[inst[0].wp] = v;    inst[0].wp = inst[0].wp + 1;
    inst[0].exp_q[inst[0].ewr] = v; inst[0].ewr = inst[0].ewr + 1;
    inst[1].mem[inst[1].wp] = v;    inst[1].wp = inst[1].wp + 1;
    inst[1].exp_q[inst[1].ewr] = v; inst[1].ewr = inst[1].ewr + 1;
  endtask

  function automatic bit drained();
    return (inst[0].erd == inst[0].ewr) && (inst[1].erd == inst[1].ewr);
  endfunction

  task automatic wait_drained(input int budget, input string name, input bit random_ready);
    int c;
    c = 0;
    while (!drained() && c < budget) begin
      @(negedge clk);
      if (random_ready) m_ready = ($urandom_range(0, 1) == 1);
      c++;
    end
    chk(0, drained(), name, c, budget);
  endtask

  task automatic run_stream();
    int written;
    for (int i = 0; i < 64; i++) push_word(DW'(i));
    repeat (4) @(negedge clk);
    phase_stream = 1;
    rst_n = 1;
    wait_drained(200, "stream_drain", 0);
    @(negedge clk);
    phase_stream = 0;

    written = 0;
    while (written < 200) begin
      @(negedge clk);
      m_ready = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) begin
        push_word($urandom);
        written++;
      end
    end
    wait_drained(3000, "backpressure_drain", 1);
    @(negedge clk);
    m_ready = 1;
    @(negedge clk);

    phase_toggle = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      push_word($urandom);
      @(negedge clk);
      @(negedge clk);
    end
    wait_drained(20, "toggle_drain", 0);
    phase_toggle = 0;
  endtask

  task automatic run_burst();
    int c;
    for (int i = 0; i < 15; i++) push_word($urandom);
    repeat (4) @(negedge clk);
    rst_n = 1;
    repeat (20) @(negedge clk);
    chk(0, inst[0].reads_total == 0, "partial_level_reads", inst[0].reads_total, 0);
    chk(1, inst[1].reads_total == 0, "partial_level_reads", inst[1].reads_total, 0);
    push_word($urandom);
    wait_drained(100, "burst1_drain", 0);
    repeat (4) @(negedge clk);
    chk(0, inst[0].reads_total == 16, "burst1_reads", inst[0].reads_total, 16);
    chk(1, inst[1].reads_total == 16, "burst1_reads", inst[1].reads_total, 16);
    chk(0, inst[0].lasts == 1, "burst1_lasts", inst[0].lasts, 1);
    chk(1, inst[1].lasts == 1, "burst1_lasts", inst[1].lasts, 1);

    for (int i = 0; i < 40; i++) push_word($urandom);
    c = 0;
    while (!(inst[0].erd + 8 >= inst[0].ewr && inst[1].erd + 8 >= inst[1].ewr) && c < 300) begin
      @(negedge clk);
      c++;
    end
    repeat (10) @(negedge clk);
    chk(0, level[0] == 8, "leftover_level", level[0], 8);
    chk(1, level[1] == 8, "leftover_level", level[1], 8);
    chk(0, inst[0].reads_total == 48, "two_burst_reads", inst[0].reads_total, 48);
    chk(1, inst[1].reads_total == 48, "two_burst_reads", inst[1].reads_total, 48);
    chk(0, inst[0].lasts == 3, "two_burst_lasts", inst[0].lasts, 3);
    chk(1, inst[1].lasts == 3, "two_burst_lasts", inst[1].lasts, 3);

    for (int i = 0; i < 8; i++) push_word($urandom);
    c = 0;
    while (inst[1].erd + 12 > inst[1].ewr && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk(1, c < 100, "mid_burst_progress", c, 100);
    rst_n = 0;
    @(negedge clk);
    inst[0].wp = inst[0].rp; inst[0].erd = inst[0].ewr;
    inst[1].wp = inst[1].rp; inst[1].erd = inst[1].ewr;
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 15; i++) push_word($urandom);
    repeat (20) @(negedge clk);
    chk(0, inst[0].reads_total == 0, "post_reset_idle", inst[0].reads_total, 0);
    chk(1, inst[1].reads_total == 0, "post_reset_idle", inst[1].reads_total, 0);
    chk(0, !m_valid[0], "post_reset_valid", m_valid[0], 0);
    chk(1, !m_valid[1], "post_reset_valid", m_valid[1], 0);
  endtask

  initial begin
    rst_n = 0;
    m_ready = 1;
`ifdef FIFO_RD_STREAM_BURST_EN
    run_burst();
`else
    run_stream();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
